// File: rtl/v_noc_scoreboard_ctrl.sv
// NoC testbench scoreboard controller: per-entry FREE/PEND/TOUT tracking,
// lowest-index allocation, key-matched retirement and one-at-a-time
// timeout reporting.
module v_noc_scoreboard_ctrl #(
   parameter int unsigned ENTRY_NUM  = 16,
   parameter int unsigned ENTRY_ID_W = $clog2(ENTRY_NUM),
   parameter int unsigned TIMEOUT_W  = 15,
   parameter int unsigned NODE_ID_W  = 4,
   parameter int unsigned TXN_ID_W   = 8
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  alloc_vld_i,
   output logic                  alloc_rdy_o,
   input  logic [NODE_ID_W-1:0]  alloc_src_id_i,
   input  logic [NODE_ID_W-1:0]  alloc_tgt_id_i,
   input  logic [TXN_ID_W-1:0]   alloc_txn_id_i,
   input  logic [TIMEOUT_W-1:0]  alloc_timeout_i,
   output logic [ENTRY_ID_W-1:0] alloc_idx_o,
   input  logic                  rec_vld_i,
   input  logic [NODE_ID_W-1:0]  rec_id_i,
   input  logic [NODE_ID_W-1:0]  rec_src_id_i,
   input  logic [TXN_ID_W-1:0]   rec_txn_id_i,
   output logic                  rec_hit_o,
   output logic                  rec_err_o,
   output logic [ENTRY_ID_W-1:0] rec_idx_o,
   output logic                  timeout_vld_o,
   output logic [ENTRY_ID_W-1:0] timeout_idx_o,
   input  logic                  timeout_rdy_i,
   output logic [ENTRY_ID_W:0]   outstanding_cnt_o,
   output logic                  idle_o
);

   localparam int unsigned CNT_W = ENTRY_ID_W + 1;

   typedef enum logic [1:0] {
      ST_FREE,
      ST_PEND,
      ST_TOUT
   } entry_st_e;

   entry_st_e             st_q  [ENTRY_NUM];
   entry_st_e             st_d  [ENTRY_NUM];
   logic [NODE_ID_W-1:0]  src_q [ENTRY_NUM];
   logic [NODE_ID_W-1:0]  src_d [ENTRY_NUM];
   logic [NODE_ID_W-1:0]  tgt_q [ENTRY_NUM];
   logic [NODE_ID_W-1:0]  tgt_d [ENTRY_NUM];
   logic [TXN_ID_W-1:0]   txn_q [ENTRY_NUM];
   logic [TXN_ID_W-1:0]   txn_d [ENTRY_NUM];
   logic [TIMEOUT_W-1:0]  thr_q [ENTRY_NUM];
   logic [TIMEOUT_W-1:0]  thr_d [ENTRY_NUM];
   logic [TIMEOUT_W-1:0]  cnt_q [ENTRY_NUM];
   logic [TIMEOUT_W-1:0]  cnt_d [ENTRY_NUM];

   logic                  rec_hit_q, rec_hit_d;
   logic                  rec_err_q, rec_err_d;
   logic [ENTRY_ID_W-1:0] rec_idx_q, rec_idx_d;
   logic [CNT_W-1:0]      out_cnt_q, out_cnt_d;

   logic                  match_any;
   logic [ENTRY_ID_W-1:0] match_idx;

   // Priority encoders over current state: lowest FREE, lowest TOUT, lowest matching PEND.
   always_comb begin
      alloc_rdy_o   = 1'b0;
      alloc_idx_o   = '0;
      timeout_vld_o = 1'b0;
      timeout_idx_o = '0;
      match_any     = 1'b0;
      match_idx     = '0;
      // Descending scan so the lowest qualifying index is the last one written.
      for (int unsigned i = ENTRY_NUM; i > 0; i--) begin
         if (st_q[i-1] == ST_FREE) begin
            alloc_rdy_o = 1'b1;
            alloc_idx_o = ENTRY_ID_W'(i-1);
         end
         if (st_q[i-1] == ST_TOUT) begin
            timeout_vld_o = 1'b1;
            timeout_idx_o = ENTRY_ID_W'(i-1);
         end
         if (rec_vld_i && st_q[i-1] == ST_PEND &&
             src_q[i-1] == rec_src_id_i && tgt_q[i-1] == rec_id_i &&
             txn_q[i-1] == rec_txn_id_i) begin
            match_any = 1'b1;
            match_idx = ENTRY_ID_W'(i-1);
         end
      end
   end

   // Next-state: timers first, then retire (overrides a same-cycle timeout), ack and alloc.
   always_comb begin
      for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
         st_d[i]  = st_q[i];
         src_d[i] = src_q[i];
         tgt_d[i] = tgt_q[i];
         txn_d[i] = txn_q[i];
         thr_d[i] = thr_q[i];
         cnt_d[i] = cnt_q[i];
         if (st_q[i] == ST_PEND && thr_q[i] != '0) begin
            if (cnt_q[i] + TIMEOUT_W'(1) == thr_q[i]) begin
               st_d[i] = ST_TOUT;
            end else if (cnt_q[i] != '1) begin
               cnt_d[i] = cnt_q[i] + TIMEOUT_W'(1);
            end
         end
      end
      rec_hit_d = 1'b0;
      rec_err_d = 1'b0;
      rec_idx_d = rec_idx_q;
      if (match_any) begin
         st_d[match_idx] = ST_FREE;
         rec_hit_d       = 1'b1;
         rec_idx_d       = match_idx;
      end else if (rec_vld_i) begin
         rec_err_d = 1'b1;
      end
      if (timeout_vld_o && timeout_rdy_i) begin
         st_d[timeout_idx_o] = ST_FREE;
      end
      if (alloc_vld_i && alloc_rdy_o) begin
         st_d[alloc_idx_o]  = ST_PEND;
         src_d[alloc_idx_o] = alloc_src_id_i;
         tgt_d[alloc_idx_o] = alloc_tgt_id_i;
         txn_d[alloc_idx_o] = alloc_txn_id_i;
         thr_d[alloc_idx_o] = alloc_timeout_i;
         cnt_d[alloc_idx_o] = '0;
      end
      out_cnt_d = '0;
      for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
         if (st_d[i] != ST_FREE) out_cnt_d = out_cnt_d + CNT_W'(1);
      end
   end

   // State and report registers; async reset discards all entries.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
            st_q[i]  <= ST_FREE;
            src_q[i] <= '0;
            tgt_q[i] <= '0;
            txn_q[i] <= '0;
            thr_q[i] <= '0;
            cnt_q[i] <= '0;
         end
         rec_hit_q <= 1'b0;
         rec_err_q <= 1'b0;
         rec_idx_q <= '0;
         out_cnt_q <= '0;
      end else begin
         for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
            st_q[i]  <= st_d[i];
            src_q[i] <= src_d[i];
            tgt_q[i] <= tgt_d[i];
            txn_q[i] <= txn_d[i];
            thr_q[i] <= thr_d[i];
            cnt_q[i] <= cnt_d[i];
         end
         rec_hit_q <= rec_hit_d;
         rec_err_q <= rec_err_d;
         rec_idx_q <= rec_idx_d;
         out_cnt_q <= out_cnt_d;
      end
   end

   assign rec_hit_o         = rec_hit_q;
   assign rec_err_o         = rec_err_q;
   assign rec_idx_o         = rec_idx_q;
   assign outstanding_cnt_o = out_cnt_q;
   assign idle_o            = (out_cnt_q == '0);

endmodule

// File: tb/tb_v_noc_scoreboard_ctrl.sv
// Directed bench for v_noc_scoreboard_ctrl: a vector table of single
// alloc/deliver pairs plus hand-written multi-cycle sequences.
module tb_v_noc_scoreboard_ctrl;

   logic        clk = 1'b0;
   logic        rstn;
   logic        alloc_vld_i;
   logic        alloc_rdy_o;
   logic [3:0]  alloc_src_id_i;
   logic [3:0]  alloc_tgt_id_i;
   logic [7:0]  alloc_txn_id_i;
   logic [14:0] alloc_timeout_i;
   logic [3:0]  alloc_idx_o;
   logic        rec_vld_i;
   logic [3:0]  rec_id_i;
   logic [3:0]  rec_src_id_i;
   logic [7:0]  rec_txn_id_i;
   logic        rec_hit_o;
   logic        rec_err_o;
   logic [3:0]  rec_idx_o;
   logic        timeout_vld_o;
   logic [3:0]  timeout_idx_o;
   logic        timeout_rdy_i;
   logic [4:0]  outstanding_cnt_o;
   logic        idle_o;

   int checks   = 0;
   int failures = 0;

   v_noc_scoreboard_ctrl #(
      .ENTRY_NUM (16),
      .TIMEOUT_W (15),
      .NODE_ID_W (4),
      .TXN_ID_W  (8)
   ) dut (
      .clk               (clk),
      .rstn              (rstn),
      .alloc_vld_i       (alloc_vld_i),
      .alloc_rdy_o       (alloc_rdy_o),
      .alloc_src_id_i    (alloc_src_id_i),
      .alloc_tgt_id_i    (alloc_tgt_id_i),
      .alloc_txn_id_i    (alloc_txn_id_i),
      .alloc_timeout_i   (alloc_timeout_i),
      .alloc_idx_o       (alloc_idx_o),
      .rec_vld_i         (rec_vld_i),
      .rec_id_i          (rec_id_i),
      .rec_src_id_i      (rec_src_id_i),
      .rec_txn_id_i      (rec_txn_id_i),
      .rec_hit_o         (rec_hit_o),
      .rec_err_o         (rec_err_o),
      .rec_idx_o         (rec_idx_o),
      .timeout_vld_o     (timeout_vld_o),
      .timeout_idx_o     (timeout_idx_o),
      .timeout_rdy_i     (timeout_rdy_i),
      .outstanding_cnt_o (outstanding_cnt_o),
      .idle_o            (idle_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] src;
      logic [3:0] tgt;
      logic [7:0] txn;
      logic [3:0] d_rec;
      logic [3:0] d_src;
      logic [7:0] d_txn;
      logic       exp_hit;
      logic       exp_err;
      logic [4:0] exp_out;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rstn            = 1'b0;
      alloc_vld_i     = 1'b0;
      alloc_src_id_i  = '0;
      alloc_tgt_id_i  = '0;
      alloc_txn_id_i  = '0;
      alloc_timeout_i = '0;
      rec_vld_i       = 1'b0;
      rec_id_i        = '0;
      rec_src_id_i    = '0;
      rec_txn_id_i    = '0;
      timeout_rdy_i   = 1'b0;
      tick();
      tick();
      rstn = 1'b1;
      tick();
   endtask

   task automatic alloc(input logic [3:0] s, input logic [3:0] t, input logic [7:0] x,
                        input logic [14:0] th, input logic [3:0] exp_idx);
      chk("alloc_rdy", 32'(alloc_rdy_o), 32'd1);
      chk("alloc_idx", 32'(alloc_idx_o), 32'(exp_idx));
      alloc_vld_i     = 1'b1;
      alloc_src_id_i  = s;
      alloc_tgt_id_i  = t;
      alloc_txn_id_i  = x;
      alloc_timeout_i = th;
      tick();
      alloc_vld_i = 1'b0;
   endtask

   task automatic deliver(input logic [3:0] r, input logic [3:0] s, input logic [7:0] x,
                          input logic eh, input logic ee, input logic [3:0] ei);
      rec_vld_i    = 1'b1;
      rec_id_i     = r;
      rec_src_id_i = s;
      rec_txn_id_i = x;
      tick();
      rec_vld_i = 1'b0;
      chk("rec_hit", 32'(rec_hit_o), 32'(eh));
      chk("rec_err", 32'(rec_err_o), 32'(ee));
      if (eh) chk("rec_idx", 32'(rec_idx_o), 32'(ei));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      //            src   tgt   txn    rec   src   txn    hit   err  out
      vecs[0] = '{4'h1, 4'h2, 8'h05, 4'h2, 4'h1, 8'h05, 1'b1, 1'b0, 5'd0};
      vecs[1] = '{4'h1, 4'h2, 8'h05, 4'h2, 4'h3, 8'h05, 1'b0, 1'b1, 5'd1};
      vecs[2] = '{4'h1, 4'h2, 8'h05, 4'h4, 4'h1, 8'h05, 1'b0, 1'b1, 5'd1};
      vecs[3] = '{4'h1, 4'h2, 8'h05, 4'h2, 4'h1, 8'h06, 1'b0, 1'b1, 5'd1};
      vecs[4] = '{4'hF, 4'hF, 8'hFF, 4'hF, 4'hF, 8'hFF, 1'b1, 1'b0, 5'd0};
      vecs[5] = '{4'hA, 4'h5, 8'hA5, 4'hA, 4'h5, 8'hA5, 1'b0, 1'b1, 5'd1};

      // Reset values
      do_reset();
      chk("rst_alloc_rdy", 32'(alloc_rdy_o), 32'd1);
      chk("rst_alloc_idx", 32'(alloc_idx_o), 32'd0);
      chk("rst_idle", 32'(idle_o), 32'd1);
      chk("rst_out", 32'(outstanding_cnt_o), 32'd0);
      chk("rst_tvld", 32'(timeout_vld_o), 32'd0);
      chk("rst_hit", 32'(rec_hit_o), 32'd0);
      chk("rst_err", 32'(rec_err_o), 32'd0);
      chk("rst_idx", 32'(rec_idx_o), 32'd0);

      // Table: single alloc (thr=0) then one delivery
      for (int v = 0; v < 6; v++) begin
         do_reset();
         alloc(vecs[v].src, vecs[v].tgt, vecs[v].txn, 15'd0, 4'd0);
         chk("vec_out_after_alloc", 32'(outstanding_cnt_o), 32'd1);
         chk("vec_idle_after_alloc", 32'(idle_o), 32'd0);
         deliver(vecs[v].d_rec, vecs[v].d_src, vecs[v].d_txn,
                 vecs[v].exp_hit, vecs[v].exp_err, 4'd0);
         chk("vec_out", 32'(outstanding_cnt_o), 32'(vecs[v].exp_out));
         chk("vec_idle", 32'(idle_o), 32'(vecs[v].exp_out == 5'd0));
      end

      // Timeout with thr=10, held ack, then late delivery
      do_reset();
      alloc(4'h3, 4'h4, 8'h10, 15'd10, 4'd0);
      for (int k = 1; k < 10; k++) begin
         tick();
         chk("to_early_vld", 32'(timeout_vld_o), 32'd0);
      end
      tick();
      chk("to_vld", 32'(timeout_vld_o), 32'd1);
      chk("to_idx", 32'(timeout_idx_o), 32'd0);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("to_hold_vld", 32'(timeout_vld_o), 32'd1);
         chk("to_hold_idx", 32'(timeout_idx_o), 32'd0);
      end
      chk("to_out_tout", 32'(outstanding_cnt_o), 32'd1);
      timeout_rdy_i = 1'b1;
      tick();
      timeout_rdy_i = 1'b0;
      chk("to_ack_vld", 32'(timeout_vld_o), 32'd0);
      chk("to_ack_out", 32'(outstanding_cnt_o), 32'd0);
      deliver(4'h4, 4'h3, 8'h10, 1'b0, 1'b1, 4'd0);
      tick();
      chk("err_one_cycle", 32'(rec_err_o), 32'd0);

      // Fill all 16 entries, ignored 17th request, retire entry 7
      do_reset();
      for (int i = 0; i < 16; i++) alloc(4'h1, 4'h2, 8'(i), 15'd0, 4'(i));
      chk("full_rdy", 32'(alloc_rdy_o), 32'd0);
      chk("full_out", 32'(outstanding_cnt_o), 32'd16);
      alloc_vld_i    = 1'b1;
      alloc_txn_id_i = 8'h77;
      tick();
      alloc_vld_i = 1'b0;
      chk("full_ignored_out", 32'(outstanding_cnt_o), 32'd16);
      chk("full_ignored_rdy", 32'(alloc_rdy_o), 32'd0);
      deliver(4'h2, 4'h1, 8'd7, 1'b1, 1'b0, 4'd7);
      chk("refree_rdy", 32'(alloc_rdy_o), 32'd1);
      chk("refree_idx", 32'(alloc_idx_o), 32'd7);
      chk("refree_out", 32'(outstanding_cnt_o), 32'd15);

      // Duplicate keys retire lowest index first
      do_reset();
      alloc(4'h6, 4'h9, 8'h42, 15'd0, 4'd0);
      alloc(4'h6, 4'h9, 8'h42, 15'd0, 4'd1);
      deliver(4'h9, 4'h6, 8'h42, 1'b1, 1'b0, 4'd0);
      deliver(4'h9, 4'h6, 8'h42, 1'b1, 1'b0, 4'd1);
      deliver(4'h9, 4'h6, 8'h42, 1'b0, 1'b1, 4'd0);

      // Retire in the timeout-transition cycle wins (thr=4)
      do_reset();
      alloc(4'h2, 4'h3, 8'h33, 15'd4, 4'd0);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("race_pre_vld", 32'(timeout_vld_o), 32'd0);
      end
      deliver(4'h3, 4'h2, 8'h33, 1'b1, 1'b0, 4'd0);
      chk("race_vld", 32'(timeout_vld_o), 32'd0);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("race_post_vld", 32'(timeout_vld_o), 32'd0);
      end
      chk("race_idle", 32'(idle_o), 32'd1);

      // Mid-stream reset with one TOUT entry and a delivery in flight
      do_reset();
      alloc(4'h1, 4'h1, 8'h01, 15'd0, 4'd0);
      alloc(4'h2, 4'h2, 8'h02, 15'd2, 4'd1);
      alloc(4'h3, 4'h3, 8'h03, 15'd0, 4'd2);
      tick();
      chk("mid_tvld", 32'(timeout_vld_o), 32'd1);
      chk("mid_tidx", 32'(timeout_idx_o), 32'd1);
      chk("mid_out", 32'(outstanding_cnt_o), 32'd3);
      rec_vld_i    = 1'b1;
      rec_id_i     = 4'h1;
      rec_src_id_i = 4'h1;
      rec_txn_id_i = 8'h01;
      #2;
      rstn = 1'b0;
      #1;
      chk("arst_out", 32'(outstanding_cnt_o), 32'd0);
      chk("arst_idle", 32'(idle_o), 32'd1);
      chk("arst_tvld", 32'(timeout_vld_o), 32'd0);
      chk("arst_rdy", 32'(alloc_rdy_o), 32'd1);
      rec_vld_i = 1'b0;
      tick();
      rstn = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("post_hit", 32'(rec_hit_o), 32'd0);
         chk("post_err", 32'(rec_err_o), 32'd0);
         chk("post_tvld", 32'(timeout_vld_o), 32'd0);
         chk("post_idle", 32'(idle_o), 32'd1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
